// File: rtl/cpu_bus_scheduler.sv
// rtl/cpu_bus_scheduler.sv - CPU memory port arbiter (IE > IF) with OAM DMA sequencer
//
// Optional feature macro: BUS_STARVE_GUARD_EN (IF starvation guard).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   if_req/if_addr             IF read request; if_gnt, if_rvalid back
//   ie_req/ie_we/ie_addr/ie_wdata  IE load/store request; ie_gnt, ie_rvalid back
//   rdata                      mem_rdata passed through to both requesters
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  system memory port
//   dma_busy                   OAM DMA in progress, CPU requesters stalled
module cpu_bus_scheduler #(
    parameter logic [15:0] OAM_DMA_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
`ifdef BUS_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        ie_req,
    input  logic        ie_we,
    input  logic [15:0] ie_addr,
    input  logic [7:0]  ie_wdata,
    output logic        ie_gnt,
    output logic        ie_rvalid,
    output logic [7:0]  rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_RD,
        S_WR
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] page, page_nxt;
    logic       parity;
    logic       trig_par, trig_par_nxt;
    logic       if_force;

`ifdef BUS_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    // Only IDLE cycles count; the counter holds its value across a DMA.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (!if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    assign if_force = (starve_cnt == SW'(STARVE_LIMIT));
`else
    assign if_force = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        page_nxt     = page;
        trig_par_nxt = trig_par;
        if_gnt       = 1'b0;
        ie_gnt       = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 16'h0000;
        mem_wdata    = 8'h00;
        // Everything combinational is held quiet while rst is asserted so
        // an aborted DMA cannot issue another write in the reset cycle.
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (ie_req && !(if_force && if_req)) begin
                        ie_gnt = 1'b1;
                        if (ie_we && (ie_addr == OAM_DMA_ADDR)) begin
                            // Trigger store is swallowed; it never reaches memory.
                            page_nxt     = ie_wdata;
                            trig_par_nxt = parity;
                            state_nxt    = S_HALT;
                        end else begin
                            mem_en    = 1'b1;
                            mem_we    = ie_we;
                            mem_addr  = ie_addr;
                            mem_wdata = ie_wdata;
                        end
                    end else if (if_req) begin
                        if_gnt   = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = if_addr;
                    end
                end
                S_HALT: begin
                    // Odd trigger parity costs one extra alignment cycle.
                    state_nxt = trig_par ? S_ALIGN : S_RD;
                end
                S_ALIGN: begin
                    state_nxt = S_RD;
                end
                S_RD: begin
                    mem_en    = 1'b1;
                    mem_addr  = {page, cnt};
                    state_nxt = S_WR;
                end
                S_WR: begin
                    // Byte read in RD arrives on mem_rdata this cycle.
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = OAM_DATA_ADDR;
                    mem_wdata = mem_rdata;
                    cnt_nxt   = cnt + 8'd1;
                    state_nxt = (cnt == 8'hFF) ? S_IDLE : S_RD;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 8'h00;
            page      <= 8'h00;
            parity    <= 1'b0;
            trig_par  <= 1'b0;
            if_rvalid <= 1'b0;
            ie_rvalid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            page      <= page_nxt;
            parity    <= ~parity;
            trig_par  <= trig_par_nxt;
            if_rvalid <= if_gnt;
            ie_rvalid <= ie_gnt & ~ie_we;
        end
    end

    assign dma_busy = !rst && (state != S_IDLE);
    assign rdata    = mem_rdata;

endmodule

// File: doc/cpu_bus_scheduler.md
Name: cpu_bus_scheduler

Overview:
- Owns the CPU's single memory port and shares it between the instruction-fetch stage (IF, read-only) and the execute stage (IE, read/write).
- Contains the OAM DMA sequencer. An IE store to the DMA trigger address halts both CPU requesters and copies one 256-byte page to the PPU OAM data port.
- Sits between the IF/IE pipeline and the system memory map.

Parameters:
- OAM_DMA_ADDR, 16'h4014: IE write address that triggers DMA. The write is consumed and not forwarded to memory.
- OAM_DATA_ADDR, 16'h2004: DMA destination address, written 256 times.
- STARVE_LIMIT, 4: consecutive IF denials before IF is forced to win. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  IF read request
- if_addr  in  16  IF address
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid on rdata (1 cycle after if_gnt)
- ie_req  in  1  IE request
- ie_we  in  1  1 = store, 0 = load
- ie_addr  in  16  IE address
- ie_wdata  in  8  IE store data
- ie_gnt  out  1  IE request accepted this cycle
- ie_rvalid  out  1  IE load data valid on rdata (1 cycle after a granted load)
- rdata  out  8  mem_rdata passed through to requesters
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid 1 cycle after a read strobe
- dma_busy  out  1  DMA in progress; CPU requesters are stalled

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, parity flop 0, if_rvalid/ie_rvalid flops 0, starve counter 0.
- Parity flop toggles every cycle out of reset.
- Grant outputs and mem_en/mem_we/mem_addr/mem_wdata are combinational from state and requests.
- if_rvalid and ie_rvalid are registered one-cycle delays of a granted read.
- Requesters hold req/addr/data stable until gnt.
- At most one memory access per cycle.

IDLE:
- Priority is IE > IF.
- IE granted and ie_we=1 and ie_addr==OAM_DMA_ADDR:
  - ie_gnt=1, mem_en=0.
  - Capture page = ie_wdata and trigger parity = parity flop.
  - Next state HALT; dma_busy=1 from the next cycle.
- Otherwise the winner drives the memory port with mem_en=1.
- The loser's gnt=0.

HALT, one cycle:
- Next state ALIGN if trigger parity=1, else RD.

ALIGN, one cycle, idle:
- Next state RD.

RD:
- mem_en=1, mem_we=0, mem_addr={page, cnt}.
- Next state WR.

WR:
- mem_en=1, mem_we=1, mem_addr=OAM_DATA_ADDR, mem_wdata=mem_rdata.
- cnt increments (8-bit).
- If cnt was 8'hFF, cnt wraps to 0, next state IDLE, dma_busy=0. Otherwise next state RD.

DMA timing:
- dma_busy is high for exactly 513 cycles (trigger parity even) or 514 cycles (odd).
- While dma_busy=1: if_gnt=0, ie_gnt=0, no rvalid generated.
- Pending requests are serviced after DMA, IE first.

Boundary conditions:
- A page-FF DMA reads FF00..FFFF; the address does not carry into the page.
- An IE load from OAM_DMA_ADDR is an ordinary read and does not trigger DMA.
- A simultaneous IF and IE trigger store: IE is granted, IF is held off until DMA completes.
- rst mid-DMA: IDLE on the next edge, dma_busy=0, cnt=0, no further memory writes.

Optional Feature:
- Macro: BUS_STARVE_GUARD_EN.
- When defined:
  - Starve counter increments each IDLE cycle with if_req=1 and if_gnt=0.
  - Counter clears on if_gnt or when if_req=0.
  - When counter==STARVE_LIMIT, IF wins the next IDLE arbitration over IE.
  - Counter is frozen during DMA.
- When undefined: pure fixed priority, IE > IF, and no counter logic is present.

Test Plan:
- IF-only read: if_req, if_addr=16'h0200, memory holds 8'hA2 there -> if_gnt same cycle, mem_addr=0200; next cycle if_rvalid=1, rdata=8'hA2.
- Contention: if_req and ie_req (load 16'h0003 = 8'h04) in the same cycle -> ie_gnt=1, if_gnt=0; next cycle ie_rvalid=1, rdata=8'h04; IF granted the following cycle.
- DMA, even parity: IE stores 8'h02 to 16'h4014 -> dma_busy high 513 cycles; 256 reads 0200..02FF, each followed by a write of the same byte to 2004; no CPU grants during DMA.
- DMA, odd parity with page FF: trigger on an odd cycle with page 8'hFF -> dma_busy 514 cycles; last read address 16'hFFFF; no carry address seen.
- Reset mid-DMA: assert rst at byte 100 -> next cycle dma_busy=0, mem_en=0, and IF granted once rst drops.
- BUS_STARVE_GUARD_EN defined: ie_req and if_req held continuously -> IF granted on the 5th cycle (STARVE_LIMIT=4), then IE resumes. Undefined -> IF never granted.
